// File: rtl/regfile_pkg.sv
// Shared types and sizing helpers for the multi-port register file.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  // Never returns 0, so a two-entry file still gets a 1-bit address.
  function automatic int addr_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  typedef logic [XLEN_DEF-1:0]          xword_t;
  typedef logic [addr_w(NREGS_DEF)-1:0] regaddr_t;

endpackage

// File: rtl/regfile_wr_arb.sv
// Resolves all write ports against one address: highest-index enabled port wins.
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_w(NREGS)
) (
  input  logic [AW-1:0]       i_addr,
  input  logic [NWR-1:0]      i_wr_en,
  input  logic [NWR*AW-1:0]   i_wr_addr,
  input  logic [NWR*XLEN-1:0] i_wr_data,
  output logic [NWR-1:0]      o_win_oh,
  output logic [XLEN-1:0]     o_data,
  output logic                o_hit
);

  logic w_blocked;

  // Register 0 is hardwired when ZERO_REG is set, so it never sees a write.
  assign w_blocked = (ZERO_REG != 0) && (i_addr == '0);

  always_comb begin
    o_win_oh = '0;
    o_data   = '0;
    o_hit    = 1'b0;
    for (int p = 0; p < NWR; p++) begin
      if (i_wr_en[p] && (i_wr_addr[p*AW +: AW] == i_addr) && !w_blocked) begin
        o_win_oh    = '0;
        o_win_oh[p] = 1'b1;
        o_data      = i_wr_data[p*XLEN +: XLEN];
        o_hit       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: registered reads with write-first bypass,
// optional hardwired zero register and a per-register busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_w(NREGS)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NRD-1:0]      i_rd_en,
  input  logic [NRD*AW-1:0]   i_rd_addr,
  output logic [NRD*XLEN-1:0] o_rd_data,
  output logic [NRD-1:0]      o_rd_busy,
  input  logic [NWR-1:0]      i_wr_en,
  input  logic [NWR*AW-1:0]   i_wr_addr,
  input  logic [NWR*XLEN-1:0] i_wr_data,
  input  logic                i_resv_en,
  input  logic [AW-1:0]       i_resv_addr,
  input  logic                i_flush
);

  logic [XLEN-1:0]  w_mem [NREGS];
  logic [NREGS-1:0] w_wr_clr;
  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;
  logic             w_resv_ok;

  for (genvar g = 0; g < NREGS; g++) begin : g_reg
    localparam logic [AW-1:0] C_ADDR = AW'(g);

    logic [NWR-1:0]  w_oh;
    logic [XLEN-1:0] w_data;
    logic            w_hit;
    logic [XLEN-1:0] r_val;

    regfile_wr_arb #(
      .XLEN     (XLEN),
      .NREGS    (NREGS),
      .NWR      (NWR),
      .ZERO_REG (ZERO_REG)
    ) u_arb (
      .i_addr    (C_ADDR),
      .i_wr_en   (i_wr_en),
      .i_wr_addr (i_wr_addr),
      .i_wr_data (i_wr_data),
      .o_win_oh  (w_oh),
      .o_data    (w_data),
      .o_hit     (w_hit)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        r_val <= '0;
      end else if (w_hit) begin
        r_val <= w_data;
      end
    end

    assign w_mem[g]    = r_val;
    assign w_wr_clr[g] = |w_oh;
  end

  assign w_resv_ok = i_resv_en && !((ZERO_REG != 0) && (i_resv_addr == '0));

  // Writes clear, a reservation is newer than a write, flush beats both.
  always_comb begin
    w_busy_nxt = r_busy & ~w_wr_clr;
    if (w_resv_ok) begin
      w_busy_nxt[i_resv_addr] = 1'b1;
    end
    if (i_flush) begin
      w_busy_nxt = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [NWR-1:0]  w_byp_oh;
    logic [XLEN-1:0] w_byp_data;
    logic            w_byp_hit;
    logic            w_zero;
    logic [XLEN-1:0] w_data_rd;
    logic            w_busy_rd;
    logic [XLEN-1:0] r_data;
    logic            r_bsy;

    assign w_addr = i_rd_addr[i*AW +: AW];
    assign w_zero = (ZERO_REG != 0) && (w_addr == '0);

    regfile_wr_arb #(
      .XLEN     (XLEN),
      .NREGS    (NREGS),
      .NWR      (NWR),
      .ZERO_REG (ZERO_REG)
    ) u_byp (
      .i_addr    (w_addr),
      .i_wr_en   (i_wr_en),
      .i_wr_addr (i_wr_addr),
      .i_wr_data (i_wr_data),
      .o_win_oh  (w_byp_oh),
      .o_data    (w_byp_data),
      .o_hit     (w_byp_hit)
    );

    // Busy as seen after this cycle's writes but before its reservation.
    assign w_data_rd = w_byp_hit ? w_byp_data : w_mem[w_addr];
    assign w_busy_rd = r_busy[w_addr] & ~(|w_byp_oh);

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        r_data <= '0;
        r_bsy  <= 1'b0;
      end else if (i_rd_en[i]) begin
        r_data <= w_zero ? '0 : w_data_rd;
        r_bsy  <= w_zero ? 1'b0 : w_busy_rd;
      end
    end

    assign o_rd_data[i*XLEN +: XLEN] = r_data;
    assign o_rd_busy[i]              = r_bsy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp (NRD=2, NWR=2) using directed vectors.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int XL = 32;
  localparam int AW = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [1:0]     rd_en = '0;
  logic [2*AW-1:0] rd_addr = '0;
  logic [2*XL-1:0] rd_data;
  logic [1:0]     rd_busy;
  logic [1:0]     wr_en = '0;
  logic [2*AW-1:0] wr_addr = '0;
  logic [2*XL-1:0] wr_data = '0;
  logic           resv_en = 1'b0;
  regaddr_t       resv_addr = '0;
  logic           flush = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         port;
    xword_t     data;
    logic       busy;
    string      name;
  } exp_t;

  exp_t       sb_q[$];
  logic [1:0] vld;

  always #5 clk = ~clk;

  regfile_mp #(
    .XLEN(XL), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_rd_en     (rd_en),
    .i_rd_addr   (rd_addr),
    .o_rd_data   (rd_data),
    .o_rd_busy   (rd_busy),
    .i_wr_en     (wr_en),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .i_resv_en   (resv_en),
    .i_resv_addr (resv_addr),
    .i_flush     (flush)
  );

  // A read issued at an edge presents its result until the next edge.
  always @(posedge clk or posedge rst) begin
    if (rst) vld <= '0;
    else     vld <= rd_en;
  end

  always @(negedge clk) begin
    exp_t e;
    for (int p = 0; p < 2; p++) begin
      if (vld[p]) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_read port%0d: got data=%h busy=%b, no expectation queued",
                   p, rd_data[p*XL +: XL], rd_busy[p]);
        end else begin
          e = sb_q.pop_front();
          if (e.port != p || rd_data[p*XL +: XL] !== e.data || rd_busy[p] !== e.busy) begin
            n_fail++;
            $display("FAIL %s port%0d: got data=%h busy=%b, expected port%0d data=%h busy=%b",
                     e.name, p, rd_data[p*XL +: XL], rd_busy[p], e.port, e.data, e.busy);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [XL-1:0] got, input logic [XL-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic rd(input int p, input int a, input logic [XL-1:0] d, input logic b,
                    input string nm);
    exp_t e;
    rd_en[p] = 1'b1;
    rd_addr[p*AW +: AW] = AW'(a);
    e.port = p; e.data = d; e.busy = b; e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic wr(input int p, input int a, input logic [XL-1:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_data[p*XL +: XL] = d;
  endtask

  task automatic resv(input int a);
    resv_en   = 1'b1;
    resv_addr = AW'(a);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rd_en = '0; wr_en = '0; resv_en = 1'b0; flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_data0", rd_data[XL-1:0], 32'h0);
    chk("reset_data1", rd_data[2*XL-1:XL], 32'h0);
    chk("reset_busy", {30'h0, rd_busy}, 32'h0);
    rst = 1'b0;

    for (int a = 1; a < 32; a++) begin
      rd(0, a, 32'h0, 1'b0, "init_read");
      rd(1, a, 32'h0, 1'b0, "init_read");
      tick();
    end

    wr(0, 5, 32'hDEADBEEF);
    rd(0, 5, 32'hDEADBEEF, 1'b0, "bypass_r5");
    tick();
    rd(0, 5, 32'hDEADBEEF, 1'b0, "array_r5");
    tick();

    wr(0, 7, 32'h11111111);
    wr(1, 7, 32'h22222222);
    rd(1, 7, 32'h22222222, 1'b0, "conflict_bypass_r7");
    tick();
    rd(0, 7, 32'h22222222, 1'b0, "conflict_array_r7");
    tick();
    tick();
    chk("hold_data0", rd_data[XL-1:0], 32'h22222222);
    chk("hold_data1", rd_data[2*XL-1:XL], 32'h22222222);
    chk("hold_busy", {30'h0, rd_busy}, 32'h0);

    wr(0, 0, 32'h12345678);
    resv(0);
    rd(0, 0, 32'h0, 1'b0, "zero_same_cycle");
    tick();
    rd(1, 0, 32'h0, 1'b0, "zero_after");
    tick();

    resv(9);
    rd(0, 9, 32'h0, 1'b0, "resv_same_cycle_r9");
    tick();
    rd(0, 9, 32'h0, 1'b1, "resv_next_cycle_r9");
    tick();
    wr(0, 9, 32'h000000A5);
    rd(0, 9, 32'h000000A5, 1'b0, "write_clears_busy_r9");
    tick();
    resv(9);
    wr(0, 9, 32'h0000005A);
    rd(1, 9, 32'h0000005A, 1'b0, "resv_and_write_bypass_r9");
    tick();
    rd(0, 9, 32'h0000005A, 1'b1, "resv_beats_write_r9");
    tick();

    wr(0, 3, 32'h00000033);
    resv(3);
    tick();
    resv(4);
    tick();
    rd(0, 3, 32'h00000033, 1'b1, "busy_r3");
    rd(1, 4, 32'h0, 1'b1, "busy_r4");
    tick();
    flush = 1'b1;
    resv(6);
    tick();
    rd(0, 3, 32'h00000033, 1'b0, "flush_r3");
    rd(1, 4, 32'h0, 1'b0, "flush_r4");
    tick();
    rd(0, 6, 32'h0, 1'b0, "flush_beats_resv_r6");
    tick();

    resv(9);
    tick();
    rd(0, 3, 32'h00000033, 1'b0, "pre_reset_r3");
    rd(1, 9, 32'h0000005A, 1'b1, "pre_reset_r9");
    tick();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midreset_data0", rd_data[XL-1:0], 32'h0);
    chk("midreset_data1", rd_data[2*XL-1:XL], 32'h0);
    chk("midreset_busy", {30'h0, rd_busy}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd(0, 3, 32'h0, 1'b0, "post_reset_r3");
    rd(1, 9, 32'h0, 1'b0, "post_reset_r9");
    tick();
    rd(0, 5, 32'h0, 1'b0, "post_reset_r5");
    tick();

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file with registered reads, write-to-read bypass, hardwired zero register and a per-register busy scoreboard. It sits between decode and execute in the core. Decode reserves destination registers, writeback commits results, and operand reads return data together with a busy flag so issue logic can stall on unresolved hazards.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥2)
- NRD, 2, number of read ports (≥1)
- NWR, 1, number of write ports (≥1)
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes/reservations

Ports (AW = clog2(NREGS)):
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- rd_en  in  NRD  per-port read enable
- rd_addr  in  NRD×AW  read addresses
- rd_data  out  NRD×XLEN  registered read data
- rd_busy  out  NRD  registered busy flag of addressed register
- wr_en  in  NWR  per-port write enable
- wr_addr  in  NWR×AW  write addresses
- wr_data  in  NWR×XLEN  write data
- resv_en  in  1  set busy bit of resv_addr
- resv_addr  in  AW  register to reserve
- flush  in  1  clear all busy bits (pipeline squash)

## Operation
- Storage: NREGS×XLEN array plus NREGS busy bits.
- Reset (async): all registers 0, all busy bits 0, rd_data 0, rd_busy 0.
- Write: on the edge, each wr_en port writes wr_data into wr_addr and clears busy[wr_addr].
- Write conflicts: several ports to the same address in one cycle means the highest-index port wins.
- ZERO_REG=1: writes and reservations to address 0 are dropped, and reads of address 0 return data 0 and busy 0.
- Read: with rd_en[i]=1, rd_data[i] and rd_busy[i] load at the edge. With rd_en[i]=0 both hold their previous value.
- Bypass (write-first): a read in the same cycle as a write to the same address returns the new wr_data (highest-index matching port) and rd_busy=0.
- Reservation: resv_en sets busy[resv_addr] at the edge.
  - resv_en and a write to the same address in one cycle leave busy=1 (the reservation is newer).
  - A same-cycle reservation is not visible to same-cycle reads. rd_busy reflects state after writes, before the reservation.
- flush: clears every busy bit at the edge and takes priority over a same-cycle resv_en. It does not affect register data or same-cycle writes.

## Timing
- Read latency: 1 cycle (address at edge N, data valid after edge N).
- Write visibility: visible to the array from edge N. Same-cycle reads see it via the bypass.
- Busy set: visible to reads issued from cycle N+1.
- No combinational path from any input to any output.
- Reset asserted mid-operation clears all state immediately. The first edge after deassertion behaves as normal operation.

## Structure
- Shared package regfile_pkg: address-width function, the default XLEN/NREGS constants, and typedef regaddr_t / xword_t.
- One natural sub-module, regfile_wr_arb: per-address priority resolution of NWR write ports. It outputs a winning-port one-hot, merged data, and a hit flag. The array update and the read bypass both use it.
- Read ports are a generate loop. The busy scoreboard lives inline.

## Test plan
- Reset, then read r1..r31 on both ports: rd_data=0, rd_busy=0 for all.
- Write r5=0xDEADBEEF with port 0 reading r5 in the same cycle: rd_data[0]=0xDEADBEEF after the edge (bypass). The next cycle's read returns the same.
- NWR=2, both ports write r7 (0x11111111 on port 0, 0x22222222 on port 1): a subsequent read returns 0x22222222.
- Write r0=0x12345678 and reserve r0: a read of r0 returns data 0, busy 0.
- Reserve r9 at cycle N, read r9 at N (busy 0) and N+1 (busy 1). Write r9=0xA5 at N+2 with a same-cycle read: busy 0, data 0xA5. Reserve and write r9 together: busy 1 afterwards.
- Reserve r3 and r4, flush with a same-cycle resv of r6: all three read busy 0. Assert reset mid-sequence: outputs 0 immediately, and r3 data reads 0 after release.
